alu_carry_ctrl: RTL and testbench

//   Multi-channel ALU carry-in selector with the processor C flag and per-channel

---
 rtl/alu_carry_ctrl.sv | 118 +++++++++++
 tb/tb_alu_carry_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/alu_carry_ctrl.sv
// alu_carry_ctrl: per-channel adder carry-in selector with the processor C flag
// and one chain-carry register per channel for multi-byte operations.
// Optional feature macro: ALU_CARRY_DEC_EN adds the decimal-mode carry path
// (dec_mode / dec_cout) into the C flag load.
module alu_carry_ctrl #(
   parameter int   NCH   = 2,
   parameter logic C_RST = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2*NCH-1:0] mux_code,
   input  logic [NCH-1:0]   cout,
   input  logic [NCH-1:0]   cap_en,
   input  logic             chain_clr,
   input  logic             c_we,
   input  logic [1:0]       c_src,
   input  logic             db_c,
   input  logic             err_clr,
`ifdef ALU_CARRY_DEC_EN
   input  logic             dec_mode,
   input  logic             dec_cout,
`endif
   output logic [NCH-1:0]   cin_out,
   output logic             c_flag,
   output logic [NCH-1:0]   chain_vld,
   output logic             chain_err
);

   localparam logic [1:0] SEL_CHAIN = 2'b00;
   localparam logic [1:0] SEL_ZERO  = 2'b01;
   localparam logic [1:0] SEL_ONE   = 2'b10;

   logic [NCH-1:0] chain;
   logic [NCH-1:0] chain_rd;
   logic           bad_rd;
   logic           c_next;
   logic           c_alu;

   // Carry-in mux per channel; sources are registers only so no cout->cin path exists.
   always_comb begin
      cin_out  = '0;
      chain_rd = '0;
      for (int i = 0; i < NCH; i++) begin
         chain_rd[i] = (mux_code[2*i +: 2] == SEL_CHAIN);
         case (mux_code[2*i +: 2])
            SEL_CHAIN: cin_out[i] = chain[i];
            SEL_ZERO:  cin_out[i] = 1'b0;
            SEL_ONE:   cin_out[i] = 1'b1;
            default:   cin_out[i] = c_flag;
         endcase
      end
      bad_rd = |(chain_rd & ~chain_vld);
   end

   // Adder-side carry for the C flag: BCD-adjusted carry replaces cout[0] in decimal mode.
`ifdef ALU_CARRY_DEC_EN
   always_comb begin
      c_alu = dec_mode ? dec_cout : cout[0];
   end
`else
   always_comb begin
      c_alu = cout[0];
   end
`endif

   // C flag load source select.
   always_comb begin
      c_next = c_flag;
      case (c_src)
         2'b00:   c_next = c_alu;
         2'b01:   c_next = db_c;
         2'b10:   c_next = 1'b0;
         default: c_next = 1'b1;
      endcase
   end

   // Chain registers: clear beats capture, capture beats consume; a capture in the
   // same cycle as a CHAIN read leaves the new value valid (read used the old one).
   always_ff @(posedge clk) begin
      if (rst) begin
         chain     <= '0;
         chain_vld <= '0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (chain_clr) begin
               chain[i]     <= 1'b0;
               chain_vld[i] <= 1'b0;
            end else if (cap_en[i]) begin
               chain[i]     <= cout[i];
               chain_vld[i] <= 1'b1;
            end else if (chain_rd[i]) begin
               chain_vld[i] <= 1'b0;
            end
         end
      end
   end

   // Sticky error on a CHAIN read of an empty register; a new error beats err_clr.
   always_ff @(posedge clk) begin
      if (rst) begin
         chain_err <= 1'b0;
      end else if (bad_rd) begin
         chain_err <= 1'b1;
      end else if (err_clr) begin
         chain_err <= 1'b0;
      end
   end

   // Processor C flag register.
   always_ff @(posedge clk) begin
      if (rst) begin
         c_flag <= C_RST;
      end else if (c_we) begin
         c_flag <= c_next;
      end
   end

endmodule

// File: tb/tb_alu_carry_ctrl.sv
// Directed, table-driven bench for alu_carry_ctrl (NCH=2, C_RST=0).
// Build with ALU_CARRY_DEC_EN defined to also exercise the decimal carry path.
module tb_alu_carry_ctrl;

   localparam logic C_RST = 1'b0;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] mux_code;
   logic [1:0] cout;
   logic [1:0] cap_en;
   logic       chain_clr;
   logic       c_we;
   logic [1:0] c_src;
   logic       db_c;
   logic       err_clr;
`ifdef ALU_CARRY_DEC_EN
   logic       dec_mode;
   logic       dec_cout;
`endif
   logic [1:0] cin_out;
   logic       c_flag;
   logic [1:0] chain_vld;
   logic       chain_err;

   int n_tests = 0;
   int n_fail  = 0;

   alu_carry_ctrl #(.NCH(2), .C_RST(C_RST)) dut (
      .clk       (clk),
      .rst       (rst),
      .mux_code  (mux_code),
      .cout      (cout),
      .cap_en    (cap_en),
      .chain_clr (chain_clr),
      .c_we      (c_we),
      .c_src     (c_src),
      .db_c      (db_c),
      .err_clr   (err_clr),
`ifdef ALU_CARRY_DEC_EN
      .dec_mode  (dec_mode),
      .dec_cout  (dec_cout),
`endif
      .cin_out   (cin_out),
      .c_flag    (c_flag),
      .chain_vld (chain_vld),
      .chain_err (chain_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic [3:0] mc;
      logic [1:0] cout;
      logic [1:0] cap;
      logic       clr;
      logic       we;
      logic [1:0] src;
      logic       dbc;
      logic       eclr;
      logic [1:0] e_cin;   // before the edge, from current state
      logic       e_c;     // after the edge
      logic [1:0] e_vld;
      logic       e_err;
   } vec_t;

   vec_t vt[26];

   task automatic chk(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s [%0d]: got %b expected %b", name, idx, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      rst       = v.rst;
      mux_code  = v.mc;
      cout      = v.cout;
      cap_en    = v.cap;
      chain_clr = v.clr;
      c_we      = v.we;
      c_src     = v.src;
      db_c      = v.dbc;
      err_clr   = v.eclr;
   endtask

   task automatic idle();
      rst = 1'b0; mux_code = 4'b0101; cout = 2'b00; cap_en = 2'b00;
      chain_clr = 1'b0; c_we = 1'b0; c_src = 2'b00; db_c = 1'b0; err_clr = 1'b0;
   endtask

   initial begin
      // rst, mc, cout, cap, clr, we, src, dbc, eclr | cin, c, vld, err
      vt[0]  = '{1'b0,4'b0110,2'b00,2'b00,1'b0,1'b0,2'b00,1'b0,1'b0, 2'b01,1'b0,2'b00,1'b0};
      vt[1]  = '{1'b0,4'b1011,2'b00,2'b00,1'b0,1'b0,2'b00,1'b0,1'b0, 2'b10,1'b0,2'b00,1'b0};
      vt[2]  = '{1'b0,4'b0101,2'b00,2'b00,1'b0,1'b1,2'b11,1'b0,1'b0, 2'b00,1'b1,2'b00,1'b0};
      vt[3]  = '{1'b0,4'b0111,2'b00,2'b00,1'b0,1'b1,2'b10,1'b0,1'b0, 2'b01,1'b0,2'b00,1'b0};
      vt[4]  = '{1'b0,4'b0101,2'b00,2'b00,1'b0,1'b1,2'b01,1'b1,1'b0, 2'b00,1'b1,2'b00,1'b0};
      vt[5]  = '{1'b0,4'b0101,2'b10,2'b00,1'b0,1'b1,2'b00,1'b0,1'b0, 2'b00,1'b0,2'b00,1'b0};
      vt[6]  = '{1'b0,4'b0101,2'b01,2'b00,1'b0,1'b1,2'b00,1'b0,1'b0, 2'b00,1'b1,2'b00,1'b0};
      vt[7]  = '{1'b0,4'b0111,2'b11,2'b00,1'b0,1'b0,2'b10,1'b1,1'b0, 2'b01,1'b1,2'b00,1'b0};
      vt[8]  = '{1'b0,4'b0111,2'b00,2'b00,1'b0,1'b0,2'b10,1'b1,1'b0, 2'b01,1'b1,2'b00,1'b0};
      vt[9]  = '{1'b0,4'b0111,2'b10,2'b00,1'b0,1'b0,2'b10,1'b1,1'b0, 2'b01,1'b1,2'b00,1'b0};
      vt[10] = '{1'b0,4'b0101,2'b10,2'b10,1'b0,1'b0,2'b00,1'b0,1'b0, 2'b00,1'b1,2'b10,1'b0};
      vt[11] = '{1'b0,4'b0001,2'b00,2'b00,1'b0,1'b0,2'b00,1'b0,1'b0, 2'b10,1'b1,2'b00,1'b0};
      vt[12] = '{1'b0,4'b0101,2'b00,2'b00,1'b0,1'b0,2'b00,1'b0,1'b0, 2'b00,1'b1,2'b00,1'b0};
      vt[13] = '{1'b0,4'b0100,2'b00,2'b00,1'b0,1'b0,2'b00,1'b0,1'b0, 2'b00,1'b1,2'b00,1'b1};
      vt[14] = '{1'b0,4'b0100,2'b00,2'b00,1'b0,1'b0,2'b00,1'b0,1'b1, 2'b00,1'b1,2'b00,1'b1};
      vt[15] = '{1'b0,4'b0101,2'b00,2'b00,1'b0,1'b0,2'b00,1'b0,1'b1, 2'b00,1'b1,2'b00,1'b0};
      vt[16] = '{1'b0,4'b0101,2'b01,2'b01,1'b1,1'b0,2'b00,1'b0,1'b0, 2'b00,1'b1,2'b00,1'b0};
      vt[17] = '{1'b0,4'b0101,2'b01,2'b01,1'b0,1'b0,2'b00,1'b0,1'b0, 2'b00,1'b1,2'b01,1'b0};
      vt[18] = '{1'b0,4'b0100,2'b00,2'b01,1'b0,1'b0,2'b00,1'b0,1'b0, 2'b01,1'b1,2'b01,1'b0};
      vt[19] = '{1'b0,4'b0100,2'b00,2'b00,1'b0,1'b0,2'b00,1'b0,1'b0, 2'b00,1'b1,2'b00,1'b0};
      vt[20] = '{1'b0,4'b0100,2'b00,2'b00,1'b0,1'b0,2'b00,1'b0,1'b0, 2'b00,1'b1,2'b00,1'b1};
      vt[21] = '{1'b0,4'b0101,2'b00,2'b00,1'b1,1'b0,2'b00,1'b0,1'b0, 2'b00,1'b1,2'b00,1'b1};
      vt[22] = '{1'b0,4'b0101,2'b00,2'b00,1'b0,1'b0,2'b00,1'b0,1'b1, 2'b00,1'b1,2'b00,1'b0};
      vt[23] = '{1'b0,4'b0101,2'b11,2'b11,1'b0,1'b0,2'b00,1'b0,1'b0, 2'b00,1'b1,2'b11,1'b0};
      vt[24] = '{1'b1,4'b0101,2'b00,2'b00,1'b0,1'b1,2'b11,1'b0,1'b0, 2'b00,C_RST,2'b00,1'b0};
      vt[25] = '{1'b0,4'b0000,2'b00,2'b00,1'b0,1'b0,2'b00,1'b0,1'b0, 2'b00,C_RST,2'b00,1'b1};

`ifdef ALU_CARRY_DEC_EN
      dec_mode = 1'b0;
      dec_cout = 1'b0;
`endif
      idle();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_c_flag", 0, {3'b0, c_flag}, {3'b0, C_RST});
      chk("rst_chain_vld", 0, {2'b0, chain_vld}, 4'b0000);
      chk("rst_chain_err", 0, {3'b0, chain_err}, 4'b0000);

      for (int i = 0; i < 26; i++) begin
         @(negedge clk);
         drive(vt[i]);
         #1;
         chk("cin_out", i, {2'b0, cin_out}, {2'b0, vt[i].e_cin});
         @(posedge clk);
         #1;
         chk("c_flag", i, {3'b0, c_flag}, {3'b0, vt[i].e_c});
         chk("chain_vld", i, {2'b0, chain_vld}, {2'b0, vt[i].e_vld});
         chk("chain_err", i, {3'b0, chain_err}, {3'b0, vt[i].e_err});
      end

      // Captured carry on ch1 must not track cout combinationally while being read.
      @(negedge clk);
      idle();
      err_clr = 1'b1;
      cap_en  = 2'b10;
      cout    = 2'b10;
      @(negedge clk);
      idle();
      mux_code = 4'b0001;
      cout     = 2'b00;
      #1;
      chk("cin_no_cout_path_a", 100, {2'b0, cin_out}, 4'b0010);
      cout = 2'b11;
      #1;
      chk("cin_no_cout_path_b", 101, {2'b0, cin_out}, 4'b0010);
      @(posedge clk);
      #1;
      chk("chain_vld_consumed", 102, {2'b0, chain_vld}, 4'b0000);
      chk("chain_err_good_read", 103, {3'b0, chain_err}, 4'b0000);

`ifdef ALU_CARRY_DEC_EN
      @(negedge clk);
      idle();
      dec_mode = 1'b1;
      dec_cout = 1'b1;
      cout     = 2'b00;
      c_we     = 1'b1;
      c_src    = 2'b00;
      @(posedge clk);
      #1;
      chk("dec_c_flag_set", 200, {3'b0, c_flag}, 4'b0001);
      @(negedge clk);
      dec_mode = 1'b0;
      dec_cout = 1'b1;
      cout     = 2'b00;
      @(posedge clk);
      #1;
      chk("bin_c_flag_clear", 201, {3'b0, c_flag}, 4'b0000);
      @(negedge clk);
      dec_mode = 1'b0;
      c_we     = 1'b0;
`endif

      @(negedge clk);
      idle();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
